// File: rtl/cell_write_scheduler.sv
// cell_write_scheduler: round-robin arbiter sharing the cell-buffer write port
// between serial-to-parallel converters, with free-list allocation and reject retry.
`default_nettype none

module cell_write_scheduler #(
  parameter int nbrOfPorts      = 4,
  parameter int parallelWidth   = 512,
  parameter int bufferAddresses = 32,
  parameter int addressWidth    = $clog2(bufferAddresses),
  parameter int portWidth       = (nbrOfPorts > 1) ? $clog2(nbrOfPorts) : 1,
  parameter int lenWidth        = $clog2(parallelWidth) + 1,
  parameter int rejCntWidth     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [nbrOfPorts-1:0]             empty,
  input  logic [nbrOfPorts*parallelWidth-1:0] popData,
  input  logic [nbrOfPorts*lenWidth-1:0]    popLength,
  input  logic [nbrOfPorts-1:0]             popSof,
  input  logic [nbrOfPorts-1:0]             popEof,
  input  logic [nbrOfPorts-1:0]             popError,
  output logic [nbrOfPorts-1:0]             pop,
  input  logic                              freeAddrValid,
  input  logic [addressWidth-1:0]           freeAddress,
  output logic                              freeAddrPop,
  output logic                              writeEnable,
  output logic [addressWidth-1:0]           writeAddress,
  output logic [parallelWidth-1:0]          writeData,
  output logic [portWidth-1:0]              writePort,
  output logic [lenWidth-1:0]               writeLength,
  output logic                              writeSof,
  output logic                              writeEof,
  output logic                              writeError,
  input  logic                              writeRejected,
  output logic                              wroteCell,
  output logic [rejCntWidth-1:0]            rejectCount
);

  logic                     holdValid_q, holdValid_d;
  logic [parallelWidth-1:0] holdData_q,  holdData_d;
  logic [addressWidth-1:0]  holdAddr_q,  holdAddr_d;
  logic [portWidth-1:0]     holdPort_q,  holdPort_d;
  logic [lenWidth-1:0]      holdLen_q,   holdLen_d;
  logic                     holdSof_q,   holdSof_d;
  logic                     holdEof_q,   holdEof_d;
  logic                     holdErr_q,   holdErr_d;
  logic [portWidth-1:0]     rrPtr_q,     rrPtr_d;
  logic [rejCntWidth-1:0]   rejCnt_q,    rejCnt_d;

  logic                     canIssue;
  logic                     issue;
  logic                     grantFound;
  logic [portWidth-1:0]     grantIdx;
  logic [portWidth-1:0]     rrNext;
  logic [portWidth:0]       searchSum;
  logic [portWidth-1:0]     searchIdx;

  assign canIssue = !holdValid_q || !writeRejected;
  assign issue    = canIssue && freeAddrValid && grantFound;

  // Search rrPtr, rrPtr+1, ... modulo nbrOfPorts for the first non-empty converter.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    searchSum  = '0;
    searchIdx  = '0;
    for (int i = 0; i < nbrOfPorts; i++) begin
      searchSum = {1'b0, rrPtr_q} + (portWidth+1)'(i);
      if (searchSum >= (portWidth+1)'(nbrOfPorts))
        searchSum = searchSum - (portWidth+1)'(nbrOfPorts);
      searchIdx = searchSum[portWidth-1:0];
      if (!grantFound && !empty[searchIdx]) begin
        grantFound = 1'b1;
        grantIdx   = searchIdx;
      end
    end
  end

  assign rrNext = (grantIdx == portWidth'(nbrOfPorts - 1)) ? '0 : grantIdx + portWidth'(1);

  always_comb begin
    pop = '0;
    if (issue)
      pop[grantIdx] = 1'b1;
  end

  assign freeAddrPop = issue;

  always_comb begin
    holdValid_d = holdValid_q;
    holdData_d  = holdData_q;
    holdAddr_d  = holdAddr_q;
    holdPort_d  = holdPort_q;
    holdLen_d   = holdLen_q;
    holdSof_d   = holdSof_q;
    holdEof_d   = holdEof_q;
    holdErr_d   = holdErr_q;
    rrPtr_d     = rrPtr_q;
    rejCnt_d    = rejCnt_q;

    if (holdValid_q && !writeRejected)
      holdValid_d = 1'b0;

    if (holdValid_q && writeRejected && (rejCnt_q != '1))
      rejCnt_d = rejCnt_q + rejCntWidth'(1);

    // A grant overrides the clear so an accepted write can be followed back-to-back.
    if (issue) begin
      holdValid_d = 1'b1;
      holdData_d  = popData[int'(grantIdx)*parallelWidth +: parallelWidth];
      holdAddr_d  = freeAddress;
      holdPort_d  = grantIdx;
      holdLen_d   = popLength[int'(grantIdx)*lenWidth +: lenWidth];
      holdSof_d   = popSof[grantIdx];
      holdEof_d   = popEof[grantIdx];
      holdErr_d   = popError[grantIdx];
      rrPtr_d     = rrNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
      holdAddr_q  <= '0;
      holdPort_q  <= '0;
      holdLen_q   <= '0;
      holdSof_q   <= 1'b0;
      holdEof_q   <= 1'b0;
      holdErr_q   <= 1'b0;
      rrPtr_q     <= '0;
      rejCnt_q    <= '0;
    end else begin
      holdValid_q <= holdValid_d;
      holdData_q  <= holdData_d;
      holdAddr_q  <= holdAddr_d;
      holdPort_q  <= holdPort_d;
      holdLen_q   <= holdLen_d;
      holdSof_q   <= holdSof_d;
      holdEof_q   <= holdEof_d;
      holdErr_q   <= holdErr_d;
      rrPtr_q     <= rrPtr_d;
      rejCnt_q    <= rejCnt_d;
    end
  end

  assign writeEnable  = holdValid_q;
  assign writeAddress = holdAddr_q;
  assign writeData    = holdData_q;
  assign writePort    = holdPort_q;
  assign writeLength  = holdLen_q;
  assign writeSof     = holdSof_q;
  assign writeEof     = holdEof_q;
  assign writeError   = holdErr_q;
  assign wroteCell    = holdValid_q && !writeRejected;
  assign rejectCount  = rejCnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cell_write_scheduler.sv
// tb_cell_write_scheduler: directed-vector bench for cell_write_scheduler.
`default_nettype none

module tb_cell_write_scheduler;

  localparam int NP  = 4;
  localparam int PW  = 64;
  localparam int AW  = 5;
  localparam int PTW = 2;
  localparam int LW  = 7;
  localparam int RCW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     empty;
  logic [NP*PW-1:0]  popData;
  logic [NP*LW-1:0]  popLength;
  logic [NP-1:0]     popSof, popEof, popError;
  logic [NP-1:0]     pop;
  logic              freeAddrValid;
  logic [AW-1:0]     freeAddress;
  logic              freeAddrPop;
  logic              writeEnable;
  logic [AW-1:0]     writeAddress;
  logic [PW-1:0]     writeData;
  logic [PTW-1:0]    writePort;
  logic [LW-1:0]     writeLength;
  logic              writeSof, writeEof, writeError;
  logic              writeRejected;
  logic              wroteCell;
  logic [RCW-1:0]    rejectCount;

  int nChecks = 0;
  int nFail   = 0;

  cell_write_scheduler #(
    .nbrOfPorts(NP), .parallelWidth(PW), .bufferAddresses(32), .rejCntWidth(RCW)
  ) dut (
    .clk(clk), .rst(rst), .empty(empty), .popData(popData), .popLength(popLength),
    .popSof(popSof), .popEof(popEof), .popError(popError), .pop(pop),
    .freeAddrValid(freeAddrValid), .freeAddress(freeAddress), .freeAddrPop(freeAddrPop),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .writePort(writePort), .writeLength(writeLength), .writeSof(writeSof),
    .writeEof(writeEof), .writeError(writeError), .writeRejected(writeRejected),
    .wroteCell(wroteCell), .rejectCount(rejectCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    empty         = '1;
    freeAddrValid = 1'b0;
    freeAddress   = '0;
    writeRejected = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [PW-1:0] d, input logic [LW-1:0] len,
                          input logic sof, input logic eof, input logic err);
    popData[p*PW +: PW]   = d;
    popLength[p*LW +: LW] = len;
    popSof[p]             = sof;
    popEof[p]             = eof;
    popError[p]           = err;
  endtask

  initial begin
    popData = '0; popLength = '0; popSof = '0; popEof = '0; popError = '0;
    do_reset();

    // Reset state
    chk("rst_we",    64'(writeEnable), 64'd0);
    chk("rst_addr",  64'(writeAddress), 64'd0);
    chk("rst_data",  64'(writeData), 64'd0);
    chk("rst_rej",   64'(rejectCount), 64'd0);
    chk("rst_wrote", 64'(wroteCell), 64'd0);
    chk("rst_pop",   64'(pop), 64'd0);
    chk("rst_fpop",  64'(freeAddrPop), 64'd0);

    // Single cell from port 2
    for (int p = 0; p < NP; p++) set_port(p, '0, '0, 1'b0, 1'b0, 1'b0);
    set_port(2, 64'hA5A5_A5A5_A5A5_A5A5, 7'd64, 1'b1, 1'b1, 1'b0);
    empty = 4'b1011; freeAddrValid = 1'b1; freeAddress = 5'd7;
    #1;
    chk("single_pop",  64'(pop), 64'b0100);
    chk("single_fpop", 64'(freeAddrPop), 64'd1);
    tick();
    idle_inputs();
    #1;
    chk("single_we",    64'(writeEnable), 64'd1);
    chk("single_addr",  64'(writeAddress), 64'd7);
    chk("single_port",  64'(writePort), 64'd2);
    chk("single_data",  64'(writeData), 64'hA5A5_A5A5_A5A5_A5A5);
    chk("single_len",   64'(writeLength), 64'd64);
    chk("single_sof",   64'(writeSof), 64'd1);
    chk("single_eof",   64'(writeEof), 64'd1);
    chk("single_err",   64'(writeError), 64'd0);
    chk("single_wrote", 64'(wroteCell), 64'd1);
    tick();
    chk("single_we_off", 64'(writeEnable), 64'd0);

    // Round-robin with all ports busy
    do_reset();
    for (int p = 0; p < NP; p++)
      set_port(p, 64'h0101_0101_0101_0101 * (p + 1), 7'(p + 1), 1'b0, 1'b0, (p == 3));
    for (int k = 0; k < 6; k++) begin
      empty = '0; freeAddrValid = 1'b1; freeAddress = 5'(10 + k);
      #1;
      chk("rr_pop", 64'(pop), 64'(1 << (k % 4)));
      if (k > 0) begin
        chk("rr_we",    64'(writeEnable), 64'd1);
        chk("rr_port",  64'(writePort), 64'((k - 1) % 4));
        chk("rr_addr",  64'(writeAddress), 64'(10 + k - 1));
        chk("rr_data",  64'(writeData), 64'h0101_0101_0101_0101 * (((k - 1) % 4) + 1));
      end
      tick();
    end
    idle_inputs();
    #1;
    chk("rr_last_port", 64'(writePort), 64'd1);
    chk("rr_last_addr", 64'(writeAddress), 64'd15);
    tick();

    // Reject retry: rrPtr is now 2, only port1 ready -> grant port1
    empty = 4'b1101; freeAddrValid = 1'b1; freeAddress = 5'd5;
    #1;
    chk("rej_pop1", 64'(pop), 64'b0010);
    tick();
    empty = 4'b1001; freeAddress = 5'd6; writeRejected = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rej_we",    64'(writeEnable), 64'd1);
      chk("rej_addr",  64'(writeAddress), 64'd5);
      chk("rej_port",  64'(writePort), 64'd1);
      chk("rej_pop",   64'(pop), 64'd0);
      chk("rej_fpop",  64'(freeAddrPop), 64'd0);
      chk("rej_wrote", 64'(wroteCell), 64'd0);
      tick();
    end
    writeRejected = 1'b0;
    #1;
    chk("rej_final_addr",  64'(writeAddress), 64'd5);
    chk("rej_final_wrote", 64'(wroteCell), 64'd1);
    chk("rej_count",       64'(rejectCount), 64'd3);
    chk("rej_next_pop",    64'(pop), 64'b0100);
    tick();
    idle_inputs();
    #1;
    chk("rej_next_port", 64'(writePort), 64'd2);
    chk("rej_next_addr", 64'(writeAddress), 64'd6);
    tick();

    // Free list empty, ports 0 and 3 pending
    do_reset();
    empty = 4'b0110; freeAddrValid = 1'b0;
    #1;
    chk("fl_pop0",  64'(pop), 64'd0);
    chk("fl_fpop0", 64'(freeAddrPop), 64'd0);
    tick();
    chk("fl_pop1",  64'(pop), 64'd0);
    chk("fl_we",    64'(writeEnable), 64'd0);
    freeAddrValid = 1'b1; freeAddress = 5'd9;
    #1;
    chk("fl_grant0", 64'(pop), 64'b0001);
    tick();
    empty = 4'b0111; freeAddress = 5'd10;
    #1;
    chk("fl_grant3", 64'(pop), 64'b1000);
    chk("fl_port0",  64'(writePort), 64'd0);
    chk("fl_addr0",  64'(writeAddress), 64'd9);
    tick();
    idle_inputs();
    #1;
    chk("fl_port3", 64'(writePort), 64'd3);
    chk("fl_addr3", 64'(writeAddress), 64'd10);
    tick();

    // Reject counter saturation (rrPtr=0, port0 granted)
    empty = 4'b1110; freeAddrValid = 1'b1; freeAddress = 5'd3;
    tick();
    idle_inputs();
    writeRejected = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("sat_count", 64'(rejectCount), 64'd15);
    chk("sat_we",    64'(writeEnable), 64'd1);
    chk("sat_addr",  64'(writeAddress), 64'd3);

    // Reset while a rejected cell is held (rrPtr was 1)
    rst = 1'b1;
    tick();
    chk("mid_rst_we",   64'(writeEnable), 64'd0);
    chk("mid_rst_cnt",  64'(rejectCount), 64'd0);
    chk("mid_rst_addr", 64'(writeAddress), 64'd0);
    rst = 1'b0;
    empty = '0; freeAddrValid = 1'b1; freeAddress = 5'd12; writeRejected = 1'b1;
    #1;
    chk("post_rst_pop", 64'(pop), 64'b0001);
    tick();
    writeRejected = 1'b0; empty = '1; freeAddrValid = 1'b0;
    #1;
    chk("post_rst_port",  64'(writePort), 64'd0);
    chk("post_rst_addr",  64'(writeAddress), 64'd12);
    chk("post_rst_wrote", 64'(wroteCell), 64'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cell_write_scheduler.md
Name: cell_write_scheduler

Overview:
- Shares the single cell-buffer write port between nbrOfPorts serial-to-parallel converters.
- Grants ports with a round-robin arbiter, pops the granted converter and allocates a buffer address from the free list.
- Registers the cell and address, then drives one buffer write per cycle.
- A rejected write is retried with the same cell and address; the cell is never dropped and simulation does not halt.

Parameters:
- nbrOfPorts, 4: number of converter requesters (>=1).
- parallelWidth, 512: cell data width in bits.
- bufferAddresses, 32: buffer depth.
- addressWidth, $clog2(bufferAddresses): buffer address width.
- portWidth, (nbrOfPorts>1 ? $clog2(nbrOfPorts) : 1): port index width.
- lenWidth, $clog2(parallelWidth)+1: cell length field width.
- rejCntWidth, 16: width of the reject statistic counter.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  synchronous reset, active-high.
- empty  in  nbrOfPorts  per-port converter empty flag; 0 = a cell is available.
- popData  in  nbrOfPorts*parallelWidth  per-port cell data.
- popLength  in  nbrOfPorts*lenWidth  per-port valid bits in the cell.
- popSof  in  nbrOfPorts  per-port start-of-frame flag.
- popEof  in  nbrOfPorts  per-port end-of-frame flag.
- popError  in  nbrOfPorts  per-port error flag.
- pop  out  nbrOfPorts  one-hot pop strobe to the granted converter.
- freeAddrValid  in  1  free list has an address available.
- freeAddress  in  addressWidth  head of the free list.
- freeAddrPop  out  1  consume freeAddress this cycle.
- writeEnable  out  1  buffer write request.
- writeAddress  out  addressWidth  buffer write address.
- writeData  out  parallelWidth  buffer write data.
- writePort  out  portWidth  source port of the cell.
- writeLength  out  lenWidth  cell length.
- writeSof  out  1  cell start-of-frame flag.
- writeEof  out  1  cell end-of-frame flag.
- writeError  out  1  cell error flag.
- writeRejected  in  1  buffer refused the write in this writeEnable cycle.
- wroteCell  out  1  write accepted this cycle.
- rejectCount  out  rejCntWidth  saturating count of rejected write cycles.

Behaviour:
- Hold register: valid bit plus data, address, port, length, sof, eof, error.
- Outputs are driven from the hold register.
  - writeEnable = holdValid.
  - wroteCell = holdValid & !writeRejected.
- Reset: holdValid=0 and all hold fields 0, so all write* outputs are 0.
  - rrPtr=0, rejectCount=0.
  - pop=0, freeAddrPop=0, wroteCell=0.
- Reset mid-write discards the held cell and its address. The free list is reset in the same cycle, so no address leaks.
- canIssue = !holdValid | (holdValid & !writeRejected).
  - Back-to-back issue is allowed.
  - The writeRejected->pop/freeAddrPop combinational path is accepted by design.
- Arbitration (combinational) happens when canIssue & freeAddrValid & |(~empty).
  - Grant g is the first port with empty[g]=0, searching rrPtr, rrPtr+1, ... mod nbrOfPorts.
  - On grant: pop[g]=1 and freeAddrPop=1 in the same cycle.
  - On the same clock edge: hold <= {popData[g], freeAddress, g, popLength[g], popSof[g], popEof[g], popError[g]}, holdValid<=1, and rrPtr <= (g+1) mod nbrOfPorts.
- If freeAddrValid=0: no grant, no pop, no freeAddrPop, and rrPtr is unchanged.
  - holdValid clears if the current write was accepted.
- If no port has a cell: same as above. holdValid <= 0 after an accepted write.
- Reject: holdValid & writeRejected.
  - Hold is unchanged and the same cell/address is re-driven next cycle.
  - No grant that cycle.
  - rejectCount increments and saturates at all-ones.
- Latency: pop at cycle N, then writeEnable at cycle N+1. Sustained throughput is 1 cell/cycle with no rejects.
- nbrOfPorts=1: rrPtr is constant 0 and writePort is always 0.
- empty/popData are sampled only in the grant cycle. Converter contents in non-grant cycles are irrelevant.
- writeRejected is ignored when holdValid=0.

Test Plan:
- Single cell: nbrOfPorts=4, port2 cell (sof=1, eof=1, len=64, data=0xA5..), freeAddress=7 at cycle 1 -> pop=4'b0100 and freeAddrPop=1 at cycle 1; cycle 2 writeEnable=1, writeAddress=7, writePort=2, wroteCell=1; cycle 3 writeEnable=0.
- Round-robin fairness: all 4 ports continuously non-empty, free list always valid -> grants 0,1,2,3,0,1 on consecutive cycles, one write per cycle.
- Reject retry: writeRejected=1 for 3 cycles on port1's cell at addr 5 -> writeEnable with addr 5/port1 held 4 cycles, no pop during the rejects, rejectCount=3, wroteCell pulses once; next grant is port2.
- Free list empty: freeAddrValid=0 with ports 0 and 3 pending -> pop=0, freeAddrPop=0; freeAddrValid rising -> port0 (rrPtr=0) granted first, then port3.
- Reset mid-operation: assert rst while holdValid=1 under reject -> next cycle writeEnable=0, rejectCount=0, rrPtr=0; after release, port0 is granted first.
- rejectCount saturation: rejCntWidth=4 with 20 reject cycles -> rejectCount stays at 15.
